// File: rtl/sub_seq_ctrl.sv
// Nibble-serial WIDTH-bit subtractor controller: one shared 4-bit slice, LSB first, start/done handshake.
// Optional build macro SUB_SAT_EN selects saturating unsigned results (underflow clamps diff to 0).

module subtractor_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_bin,
  output logic [3:0] o_d,
  output logic       o_bout
);
  logic [4:0] w_full;

  // The fifth bit of the widened difference is the borrow-out.
  assign w_full = {1'b0, i_a} - {1'b0, i_b} - {4'b0000, i_bin};
  assign o_d    = w_full[3:0];
  assign o_bout = w_full[4];
endmodule

module sub_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);
  localparam int NSLICE = WIDTH / 4;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_work, r_diff;
  logic [KW-1:0]    r_k;
  logic             r_borrow, r_bout, r_zero, r_done;

  logic [3:0]       w_d;
  logic             w_bo, w_last, w_accept;
  logic [WIDTH-1:0] w_result, w_final;

  subtractor_4bit u_sub (
    .i_a    (r_a[4*r_k +: 4]),
    .i_b    (r_b[4*r_k +: 4]),
    .i_bin  (r_borrow),
    .o_d    (w_d),
    .o_bout (w_bo)
  );

  assign w_last   = (r_k == KW'(NSLICE - 1));
  assign w_accept = (r_state == S_IDLE) && start;

  // Full result as it will look once the current slice is written back.
  always_comb begin
    w_result            = r_work;
    w_result[4*r_k +: 4] = w_d;
`ifdef SUB_SAT_EN
    w_final = w_bo ? '0 : w_result;
`else
    w_final = w_result;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: defaults first in a combinational block so no path leaves the output unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start)  w_state_nxt = S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_IDLE;
      default:            w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_k      <= '0;
      r_work   <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a      <= a;
        r_b      <= b;
        r_borrow <= bin;
        r_k      <= '0;
      end else if (r_state == S_RUN) begin
        r_work[4*r_k +: 4] <= w_d;
        r_borrow           <= w_bo;
        if (w_last) begin
          r_k    <= '0;
          r_diff <= w_final;
          r_bout <= w_bo;
          r_zero <= (w_final == '0);
          r_done <= 1'b1;
        end else begin
          r_k <= r_k + KW'(1);
        end
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;
  assign zero = r_zero;
endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Directed bench for sub_seq_ctrl (WIDTH=16): vector table plus handshake, back-to-back and reset corner cases.

module tb_sub_seq_ctrl;
  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             bin;
  logic             busy, done, bout, zero;
  logic [WIDTH-1:0] diff;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        zero;
  } vec_t;

  vec_t vecs [11];

  sub_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hand-computed wrap results are clamped when the saturating build is selected.
  function automatic vec_t sat_adjust(input vec_t v);
    vec_t r = v;
`ifdef SUB_SAT_EN
    if (v.bout) begin
      r.diff = '0;
      r.zero = 1'b1;
    end
`endif
    return r;
  endfunction

  // Issue one operation and follow it to completion, checking latency, busy width and held outputs.
  task automatic run_op(input string name, input vec_t v_in);
    vec_t        v;
    int          n;
    int          busy_cycles;
    logic [15:0] prev_diff;
    v = sat_adjust(v_in);
    @(negedge clk);
    prev_diff = diff;
    a = v.a; b = v.b; bin = v.bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~v.a; b = ~v.b; bin = ~v.bin;
    n = 1;
    busy_cycles = 0;
    while (!done && n < 20) begin
      if (busy) busy_cycles++;
      if (diff !== prev_diff) begin
        n_tests++; n_fail++;
        $display("FAIL %s partial: diff changed to 0x%0h before done", name, diff);
      end
      @(negedge clk);
      n++;
    end
    check({name, " done"},    32'(done), 32'd1);
    check({name, " latency"}, 32'(n), 32'(NSLICE + 1));
    check({name, " busy"},    32'(busy_cycles), 32'(NSLICE));
    check({name, " diff"},    32'(diff), 32'(v.diff));
    check({name, " bout"},    32'(bout), 32'(v.bout));
    check({name, " zero"},    32'(zero), 32'(v.zero));
    @(negedge clk);
    check({name, " pulse"},   32'(done), 32'd0);
    check({name, " hold"},    32'(diff), 32'(v.diff));
  endtask

  initial begin : main
    int   done_cnt;
    int   t_first, t_second;
    vec_t v;

    vecs[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1]  = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
    vecs[2]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[3]  = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4]  = '{16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6]  = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[7]  = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[8]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[9]  = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
    vecs[10] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst diff", 32'(diff), 32'd0);
    check("rst bout", 32'(bout), 32'd0);
    check("rst zero", 32'(zero), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);

    for (int i = 0; i < 11; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Start re-pulsed during RUN with other operands must be ignored.
    @(negedge clk);
    a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2 || c == 3) begin
        a = 16'h0F0F; b = 16'h0001; bin = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("ignore done count", 32'(done_cnt), 32'd1);
    check("ignore diff",       32'(diff), 32'h1000);
    check("ignore bout",       32'(bout), 32'd0);

    // Start held high: back-to-back operations with done spaced NSLICE+1 cycles.
    @(negedge clk);
    a = 16'h00FF; b = 16'h000F; bin = 1'b0; start = 1'b1;
    t_first = -1; t_second = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin
        if (t_first < 0) t_first = c;
        else if (t_second < 0) t_second = c;
      end
    end
    start = 1'b0;
    check("b2b first seen",  32'(t_first >= 0), 32'd1);
    check("b2b spacing",     32'(t_second - t_first), 32'(NSLICE + 1));
    check("b2b diff",        32'(diff), 32'h00F0);
    repeat (NSLICE + 2) @(negedge clk);
    check("b2b drained",     32'(busy), 32'd0);

    // Asynchronous reset after slice 1 of a run.
    v = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    run_op("pre-abort", v);
    @(negedge clk);
    a = 16'h8888; b = 16'h1111; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort diff", 32'(diff), 32'd0);
    check("abort bout", 32'(bout), 32'd0);
    check("abort zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < NSLICE + 3; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort no done", 32'(done_cnt), 32'd0);
    v = '{16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0};
    run_op("post-abort", v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
    $fatal(1);
  end
endmodule

// File: doc/sub_seq_ctrl.md
Name: sub_seq_ctrl

Overview:
Sequencing controller that performs WIDTH-bit subtraction A - B - Bin on one shared 4-bit subtractor datapath. It processes one nibble per clock, LSB slice first, and chains the borrow through an internal register. It instantiates exactly one subtractor_4bit. It sits between a requester using a start/done handshake and the arithmetic datapath, trading latency for area on wide operands.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4. NSLICE = WIDTH/4.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while idle (busy=0)
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
bin  input  1  initial borrow-in; captured on accepted start
busy  output  1  high while slices are being processed
done  output  1  one-cycle pulse when result is valid
diff  output  WIDTH  registered result; held until the next completion
bout  output  1  final borrow-out (1 = unsigned underflow)
zero  output  1  1 when the completed diff == 0

Behaviour:
- Single clock, one subtractor_4bit instance; reset is asynchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, diff=0, bout=0, zero=0; internal operand regs, borrow reg and slice counter cleared.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 at edge E0 latches a, b and bin (into the borrow reg), sets slice counter k=0, enters RUN, busy=1.
  - start=0: remain in IDLE.
- RUN, each edge:
  - Subtractor inputs are A_lat[4k+3:4k], B_lat[4k+3:4k] and the borrow reg.
  - Its difference is written into the working result slice k; its borrow-out is written to the borrow reg; k increments.
- Last slice (k = NSLICE-1):
  - On that edge (E0+NSLICE), diff receives the full working result, bout receives the slice borrow-out, zero = (result==0).
  - done=1 for exactly the following cycle; busy=0; state returns to IDLE.
- Latency: done observed high after edge E0+NSLICE; busy high for exactly NSLICE cycles.
- diff, bout and zero change only at completion. They never show partial results and hold between operations.
- start while busy=1 is ignored (not queued). Operands changing during RUN have no effect.
- start high in the cycle done=1 (state is IDLE) is accepted: back-to-back operation, no idle bubble required.
- Holding start high continuously gives one operation every NSLICE+1 cycles? No: accepted at each IDLE edge, so one operation per NSLICE cycles plus the IDLE edge, i.e. period NSLICE+1.
- Arithmetic: unsigned modulo 2^WIDTH; diff = (A - B - Bin) mod 2^WIDTH; bout=1 iff A < B + Bin.
- Reset asserted mid-RUN aborts immediately to the reset values. No done pulse is produced for the aborted operation.
- WIDTH=4 degenerates to a single RUN cycle.

Optional Feature:
SUB_SAT_EN:
- Defined: saturating unsigned mode. If the final borrow-out is 1, diff is forced to 0 and zero=1. bout still reports 1.
- Undefined: diff carries the raw modulo-2^WIDTH wrap result. Ports are identical in both builds.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0234, bin=0, start pulse at E0 -> busy 4 cycles; done one cycle after E0+4; diff=0x1000, bout=0, zero=0.
- a=0x1000, b=0x0001 -> diff=0x0FFF, bout=0 (borrow ripples through 3 slices). a=0x0000, b=0x0001 -> diff=0xFFFF, bout=1; with SUB_SAT_EN: diff=0x0000, zero=1, bout=1.
- a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1. Same with bin=0 -> diff=0x0000, zero=1, bout=0.
- Start accepted, then start pulsed again at cycles 2 and 3 with different operands -> ignored; exactly one done, result of the first operands. Start held high through done -> second operation begins immediately, done pulses spaced 5 cycles apart.
- rst asserted asynchronously mid-RUN after slice 1 -> busy, done, diff, bout, zero all 0 immediately, no done pulse. A following start with a=0x00FF, b=0x000F completes normally with diff=0x00F0.
